mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave memory arbiter that shares the unified memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write) once fetch and data memory stop being separate combinational arrays. It sits between the CPU stages and the memory model. It accepts one request at a time with round-robin priority and registers it toward memory. It returns the response to the owning master, and a watchdog aborts requests that get no response.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; mask width is `DATA_W/8`.
- `TIMEOUT`, default 255: cycles allowed from request issue to memory response; must be ≥ 2.
- `clk  in  1  clock`
- `rst  in  1  active-low asynchronous reset`
- `ifu_req_valid  in  1  IFU read request`
- `ifu_req_ready  out  1  IFU request accepted this cycle`
- `ifu_addr  in  ADDR_W  fetch address`
- `ifu_resp_valid  out  1  one-cycle response strobe to IFU`
- `ifu_rdata  out  DATA_W  fetched word`
- `ifu_resp_err  out  1  timeout flag, valid with ifu_resp_valid`
- `lsu_req_valid  in  1  LSU request`
- `lsu_req_ready  out  1  LSU request accepted this cycle`
- `lsu_addr  in  ADDR_W  data address`
- `lsu_wen  in  1  1 = write`
- `lsu_wdata  in  DATA_W  store data`
- `lsu_wmask  in  DATA_W/8  byte strobes`
- `lsu_resp_valid  out  1  one-cycle response strobe to LSU (reads and writes)`
- `lsu_rdata  out  DATA_W  load word`
- `lsu_resp_err  out  1  timeout flag`
- `mem_req_valid  out  1  request to memory`
- `mem_req_ready  in  1  memory accepts request`
- `mem_addr  out  ADDR_W  registered address`
- `mem_wen  out  1  registered write enable`
- `mem_wdata  out  DATA_W  registered store data`
- `mem_wmask  out  DATA_W/8  registered strobes; 0 for IFU requests`
- `mem_resp_valid  in  1  memory response strobe`
- `mem_rdata  in  DATA_W  memory read data`

## Operation
- The FSM has four states:
  - IDLE: pick a winner and latch its request.
  - REQ: drive `mem_req_valid`.
  - WAIT: wait for `mem_resp_valid`.
  - RESP: pulse the owner's `*_resp_valid` and return to IDLE.
- Arbitration, in IDLE only:
  - If one master is valid, it wins.
  - If both are valid, the master not granted last time wins.
  - `last_grant` resets to LSU, so IFU wins the first tie after reset.
- `*_req_ready` is combinational: `ifu_req_ready = IDLE && ifu_req_valid && winner==IFU`, and likewise for LSU. The loser's ready stays 0, so it must hold its request.
- On acceptance:
  - latch addr/wen/wdata/wmask and the owner;
  - for IFU, `wen`=0 and `wmask`=0;
  - update `last_grant`;
  - go to REQ.
- REQ to WAIT on `mem_req_ready`. The memory response may not arrive in the same cycle as `mem_req_ready`.
- WAIT to RESP on `mem_resp_valid`. Latch `mem_rdata` into the response register and set err=0.
- Watchdog counter:
  - It clears on entering REQ and increments every cycle in REQ/WAIT.
  - When it reaches `TIMEOUT` with no handshake completed, go to RESP with err=1 and rdata=0.
  - If the timeout hits in REQ, `mem_req_valid` deasserts.
- `mem_resp_valid` outside WAIT is dropped.
- Only one transaction is outstanding. No new grant is made in REQ, WAIT or RESP.

## Timing
- Reset (async, `rst`=0):
  - state IDLE, `last_grant`=LSU, counter 0;
  - all `*_resp_valid`, `*_resp_err`, `mem_req_valid`, `mem_wen` = 0;
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `*_rdata` = 0.
  - An in-flight transaction is discarded with no response.
- Best-case read, with memory ready immediately and responding the following cycle:
  - cycle 0: accept;
  - cycle 1: `mem_req_valid`=1, ready;
  - cycle 2: `mem_resp_valid`;
  - cycle 3: `*_resp_valid`.
- Minimum spacing between accepts is 4 cycles.
- `*_resp_valid` is high for exactly one cycle. `*_rdata` holds until the next response.
- `mem_*` request fields are stable while `mem_req_valid`=1.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/RESP);
  - the owner encoding (`OWN_IFU`=0, `OWN_LSU`=1);
  - the default `TIMEOUT` constant.
- Sub-module `arb_rr2` is the combinational two-way round-robin picker: inputs two valids and `last_grant`; outputs the grant one-hot.
- The FSM, watchdog and latches stay in `mem_arbiter`.

## Test plan
- IFU read only, addr `0x80000000`, memory returns `0x00000413` one cycle after ready:
  - `ifu_resp_valid` at cycle 3, rdata `0x00000413`, err 0;
  - `lsu_resp_valid` never asserts.
- Both valid on the first cycle after reset:
  - IFU is granted first, LSU after IFU's response;
  - with both held valid for 4 transactions, grants alternate IFU, LSU, IFU, LSU.
- LSU write, addr `0x80001000`, wdata `0xDEADBEEF`, wmask `4'b0011`:
  - `mem_wen`=1 and `mem_wmask`=`0011` are stable while `mem_req_ready` is held low for 5 cycles;
  - `lsu_resp_valid` follows the memory response.
- Memory never asserts `mem_resp_valid`, `TIMEOUT`=8:
  - `lsu_resp_valid` with err=1 and rdata 0 after 8 cycles in REQ/WAIT;
  - a stray `mem_resp_valid` arriving later in IDLE is ignored.
- `rst` asserted in WAIT: all outputs clear immediately; after release, a fresh IFU request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, owner encoding and default watchdog limit
// for the two-master memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker; bit 0 is IFU, bit 1 is LSU.
// On a tie the master that did not win last time is granted.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] && (!valid[1] || last_grant == OWN_LSU);
    assign grant[1] = valid[1] && (!valid[0] || last_grant == OWN_IFU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction at a
// time, with round-robin arbitration, registered request fields and a watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, next;
    logic          owner, last_grant, err;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          accept, busy, expired, hit, finish;

    arb_rr2 u_arb (
        .valid      ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign ifu_req_ready  = state == IDLE && grant[0];
    assign lsu_req_ready  = state == IDLE && grant[1];
    assign accept         = ifu_req_ready || lsu_req_ready;
    assign busy           = state == REQ || state == WAIT;
    assign expired        = cnt >= CW'(TIMEOUT - 1);
    assign hit            = state == WAIT && mem_resp_valid;
    assign finish         = busy && next == RESP;
    assign mem_req_valid  = state == REQ;
    assign ifu_resp_valid = state == RESP && owner == OWN_IFU;
    assign lsu_resp_valid = state == RESP && owner == OWN_LSU;
    assign ifu_resp_err   = ifu_resp_valid && err;
    assign lsu_resp_err   = lsu_resp_valid && err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // A completed request handshake wins over the watchdog in the same cycle.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? REQ : IDLE;
            REQ:     next = mem_req_ready ? WAIT : expired ? RESP : REQ;
            WAIT:    next = (mem_resp_valid || expired) ? RESP : WAIT;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            cnt        <= '0;
            err        <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            ifu_rdata  <= '0;
            lsu_rdata  <= '0;
        end else begin
            if (accept) begin
                owner      <= lsu_req_ready ? OWN_LSU : OWN_IFU;
                last_grant <= lsu_req_ready ? OWN_LSU : OWN_IFU;
                cnt        <= '0;
                mem_addr   <= lsu_req_ready ? lsu_addr : ifu_addr;
                mem_wen    <= lsu_req_ready && lsu_wen;
                mem_wdata  <= lsu_req_ready ? lsu_wdata : '0;
                mem_wmask  <= lsu_req_ready ? lsu_wmask : '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                err <= !hit;
                if (owner == OWN_IFU) ifu_rdata <= hit ? mem_rdata : '0;
                else                  lsu_rdata <= hit ? mem_rdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with TIMEOUT=8; inputs are
// driven on the falling edge and outputs sampled 1 time unit later.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic test_reset;
        rst = 1'b0;
        {ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready, mem_resp_valid} = '0;
        {ifu_addr, lsu_addr, lsu_wdata, mem_rdata} = '0;
        lsu_wmask = '0;
        @(negedge clk); #1;
        checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
        checks++; if ({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err} !== 4'b0) begin fails++; $display("FAIL rst_resp: got %b want 0000", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}); end
        checks++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== 69'b0) begin fails++; $display("FAIL rst_mem_fields: addr %h wdata %h wmask %b wen %b want all 0", mem_addr, mem_wdata, mem_wmask, mem_wen); end
        checks++; if ({ifu_rdata, lsu_rdata} !== 64'b0) begin fails++; $display("FAIL rst_rdata: got %h %h want 0", ifu_rdata, lsu_rdata); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Both masters held valid from the first cycle after reset; memory accepts at
    // once and responds the cycle after the handshake.
    task automatic test_round_robin;
        int   n = 0;
        int   r = 0;
        logic pend = 1'b0;
        logic gr [4];
        int   gc [4];
        logic rs [4];
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            ifu_req_valid  = n < 4;
            lsu_req_valid  = n < 4;
            ifu_addr       = 32'h8000_0100;
            lsu_addr       = 32'h8000_0200;
            mem_req_ready  = 1'b1;
            mem_resp_valid = pend;
            mem_rdata      = 32'(cyc);
            #1;
            checks++; if (ifu_req_ready && lsu_req_ready) begin fails++; $display("FAIL rr_both_ready: cycle %0d both ready, want one", cyc); end
            if ((ifu_req_ready || lsu_req_ready) && n < 4) begin gr[n] = lsu_req_ready; gc[n] = cyc; n++; end
            if ((ifu_resp_valid || lsu_resp_valid) && r < 4) begin rs[r] = lsu_resp_valid; r++; end
            pend = mem_req_valid && mem_req_ready;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        checks++; if (n !== 4 || r !== 4) begin fails++; $display("FAIL rr_count: got %0d grants %0d responses want 4 4", n, r); end
        for (int i = 0; i < n; i++) begin
            checks++; if (gr[i] !== 1'(i % 2)) begin fails++; $display("FAIL rr_grant%0d: got owner %b want %b", i, gr[i], 1'(i % 2)); end
            checks++; if (gc[i] !== 4 * i) begin fails++; $display("FAIL rr_accept_cycle%0d: got %0d want %0d", i, gc[i], 4 * i); end
        end
        for (int i = 0; i < r; i++) begin
            checks++; if (rs[i] !== 1'(i % 2)) begin fails++; $display("FAIL rr_resp%0d: got owner %b want %b", i, rs[i], 1'(i % 2)); end
        end
    endtask

    task automatic test_ifu_read;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL rd_ready: got ifu %b lsu %b want 1 0", ifu_req_ready, lsu_req_ready); end
        @(negedge clk);
        ifu_req_valid = 1'b0; ifu_addr = 32'h1111_1111;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL rd_c1_req_valid: got %b want 1", mem_req_valid); end
        checks++; if ({mem_addr, mem_wen, mem_wmask} !== {32'h8000_0000, 1'b0, 4'b0}) begin fails++; $display("FAIL rd_c1_fields: addr %h wen %b wmask %b want 80000000 0 0000", mem_addr, mem_wen, mem_wmask); end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        checks++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b0) begin fails++; $display("FAIL rd_c2: req %b ifu_resp %b lsu_resp %b want 000", mem_req_valid, ifu_resp_valid, lsu_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid} !== 3'b100) begin fails++; $display("FAIL rd_c3_resp: ifu %b err %b lsu %b want 1 0 0", ifu_resp_valid, ifu_resp_err, lsu_resp_valid); end
        checks++; if (ifu_rdata !== 32'h0000_0413) begin fails++; $display("FAIL rd_c3_rdata: got %h want 00000413", ifu_rdata); end
        @(negedge clk); #1;
        checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00 || ifu_rdata !== 32'h0000_0413) begin fails++; $display("FAIL rd_c4_hold: resp %b %b rdata %h want 0 0 00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata); end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010; mem_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_wen} !== 4'b0) begin fails++; $display("FAIL rw_ctrl: req %b resp %b %b wen %b want 0", mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_wen); end
        checks++; if ({mem_addr, ifu_rdata, lsu_rdata} !== 96'b0) begin fails++; $display("FAIL rw_data: addr %h ifu %h lsu %h want 0", mem_addr, ifu_rdata, lsu_rdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if ({ifu_resp_valid, mem_req_valid} !== 2'b00) begin fails++; $display("FAIL rw_no_stale: resp %b req %b want 0 0", ifu_resp_valid, mem_req_valid); end
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; mem_req_ready = 1'b1;
        #1;
        checks++; if (ifu_req_ready !== 1'b1) begin fails++; $display("FAIL rw_ready: got %b want 1", ifu_req_ready); end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if ({ifu_resp_valid, ifu_resp_err} !== 2'b10 || ifu_rdata !== 32'h0010_0093) begin fails++; $display("FAIL rw_fresh: resp %b err %b rdata %h want 1 0 00100093", ifu_resp_valid, ifu_resp_err, ifu_rdata); end
    endtask

    task automatic test_lsu_write;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0;
        #1;
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin fails++; $display("FAIL wr_ready: lsu %b ifu %b want 1 0", lsu_req_ready, ifu_req_ready); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = 32'(c); lsu_wmask = 4'b1100; lsu_addr = 32'h0;
            #1;
            checks++; if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b1_1_0011) begin fails++; $display("FAIL wr_hold%0d: req %b wen %b wmask %b want 1 1 0011", c, mem_req_valid, mem_wen, mem_wmask); end
            checks++; if ({mem_addr, mem_wdata} !== {32'h8000_1000, 32'hDEAD_BEEF}) begin fails++; $display("FAIL wr_fields%0d: addr %h wdata %h want 80001000 deadbeef", c, mem_addr, mem_wdata); end
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if ({mem_req_valid, lsu_resp_valid} !== 2'b00) begin fails++; $display("FAIL wr_wait: req %b resp %b want 0 0", mem_req_valid, lsu_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid} !== 3'b100) begin fails++; $display("FAIL wr_resp: lsu %b err %b ifu %b want 1 0 0", lsu_resp_valid, lsu_resp_err, ifu_resp_valid); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        for (int c = 2; c <= 8; c++) begin
            if (c > 2) @(negedge clk);
            #1;
            checks++; if (lsu_resp_valid !== 1'b0) begin fails++; $display("FAIL to_early%0d: resp %b want 0", c, lsu_resp_valid); end
        end
        @(negedge clk); #1;
        checks++; if ({lsu_resp_valid, lsu_resp_err} !== 2'b11 || lsu_rdata !== 32'h0) begin fails++; $display("FAIL to_resp: resp %b err %b rdata %h want 1 1 00000000", lsu_resp_valid, lsu_resp_err, lsu_rdata); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        checks++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b00) begin fails++; $display("FAIL to_stray: resp %b %b want 0 0", lsu_resp_valid, ifu_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if ({lsu_resp_valid, ifu_resp_valid, mem_req_valid} !== 3'b000 || lsu_rdata !== 32'h0) begin fails++; $display("FAIL to_after_stray: resp %b %b req %b rdata %h want 0 0 0 00000000", lsu_resp_valid, ifu_resp_valid, mem_req_valid, lsu_rdata); end
        // Timeout while memory never accepts the request.
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ifu_req_valid = 1'b0;
            #1;
            checks++; if ({mem_req_valid, ifu_resp_valid} !== 2'b10) begin fails++; $display("FAIL to_req%0d: req %b resp %b want 1 0", c, mem_req_valid, ifu_resp_valid); end
        end
        @(negedge clk); #1;
        checks++; if ({mem_req_valid, ifu_resp_valid, ifu_resp_err} !== 3'b011 || ifu_rdata !== 32'h0) begin fails++; $display("FAIL to_req_resp: req %b resp %b err %b rdata %h want 0 1 1 00000000", mem_req_valid, ifu_resp_valid, ifu_resp_err, ifu_rdata); end
        @(negedge clk); #1;
        checks++; if ({ifu_resp_valid, ifu_resp_err} !== 2'b00) begin fails++; $display("FAIL to_req_done: resp %b err %b want 0 0", ifu_resp_valid, ifu_resp_err); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_ifu_read;
        test_reset_in_wait;
        test_lsu_write;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
